// File: rtl/dma_copy_seq_pkg.sv
// Shared types and constants for the memory-to-memory copy sequencer.
// Optional feature macro used by the sequencer: DMA_COPY_FILL_EN.
package dma_copy_seq_pkg;

  localparam int DEF_ADDR_W = 21;
  localparam int DEF_LEN_W  = 16;

  localparam logic [1:0] CFG_SEL_SRC  = 2'd0;
  localparam logic [1:0] CFG_SEL_DST  = 2'd1;
  localparam logic [1:0] CFG_SEL_LEN  = 2'd2;
  localparam logic [1:0] CFG_SEL_CTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

endpackage

// File: rtl/dma_copy_seq_if.sv
// Config and dma_access handshake bundle for dma_copy_seq.
// master = the sequencer itself, slave = the Z80 register side plus dma_access.
interface dma_copy_seq_if
  import dma_copy_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              cfg_we;
  logic [1:0]        cfg_sel;
  logic [ADDR_W-1:0] cfg_wd;
  logic              cfg_start;
  logic              cfg_abort;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              dma_req;
  logic              dma_rnw;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_wd;
  logic              dma_busynready;
  logic [7:0]        mem_dma_rd;

  modport master (
    input  cfg_we, cfg_sel, cfg_wd, cfg_start, cfg_abort,
    input  dma_busynready, mem_dma_rd,
    output busy, done, aborted,
    output dma_req, dma_rnw, dma_addr, dma_wd
  );

  modport slave (
    output cfg_we, cfg_sel, cfg_wd, cfg_start, cfg_abort,
    output dma_busynready, mem_dma_rd,
    input  busy, done, aborted,
    input  dma_req, dma_rnw, dma_addr, dma_wd
  );

endinterface

// File: rtl/dma_copy_seq.sv
// Copy sequencer: alternating one-shot read/write requests to dma_access.
// Fill mode (write a constant byte, no reads) exists only with DMA_COPY_FILL_EN.
//
// state      | meaning
// IDLE       | config writes accepted, waiting for start
// RD_REQ     | read request held until dma_access reports busy
// RD_WAIT    | read in flight, byte captured when busy drops
// WR_REQ     | write request held until dma_access reports busy
// WR_WAIT    | write in flight, counters step when busy drops
// FIN        | one-cycle done pulse, busy already low
module dma_copy_seq
  import dma_copy_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic          clk,
  input  logic          rst_n,
  dma_copy_seq_if.master bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic              abort_pend_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic              req_q;
  logic              rnw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wd_q;
`ifdef DMA_COPY_FILL_EN
  logic              fill_q;
  logic [7:0]        fill_byte_q;
`endif

  logic abort_now;
  logic last_byte;
  logic [ADDR_W-1:0] src_inc;
  logic [ADDR_W-1:0] dst_inc;

  assign abort_now = abort_pend_q | bus.cfg_abort;
  assign last_byte = (len_q == LEN_W'(1));
  assign src_inc   = src_q + ADDR_W'(1);
  assign dst_inc   = dst_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      req_q        <= 1'b0;
      rnw_q        <= 1'b0;
      addr_q       <= '0;
      wd_q         <= '0;
`ifdef DMA_COPY_FILL_EN
      fill_q       <= 1'b0;
      fill_byte_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      // An access already handed to dma_access cannot be cancelled, so abort is deferred.
      if (state_q != ST_IDLE && state_q != ST_FIN && bus.cfg_abort)
        abort_pend_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (bus.cfg_we) begin
            case (bus.cfg_sel)
              CFG_SEL_SRC: src_q <= bus.cfg_wd;
              CFG_SEL_DST: dst_q <= bus.cfg_wd;
              CFG_SEL_LEN: len_q <= bus.cfg_wd[LEN_W-1:0];
              default: begin
`ifdef DMA_COPY_FILL_EN
                fill_q      <= bus.cfg_wd[0];
                fill_byte_q <= bus.cfg_wd[15:8];
`endif
              end
            endcase
          end
          if (bus.cfg_start) begin
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            if (len_q == '0) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              busy_q <= 1'b1;
              req_q  <= 1'b1;
`ifdef DMA_COPY_FILL_EN
              if (fill_q) begin
                state_q <= ST_WR_REQ;
                rnw_q   <= 1'b0;
                addr_q  <= dst_q;
                wd_q    <= fill_byte_q;
              end else begin
                state_q <= ST_RD_REQ;
                rnw_q   <= 1'b1;
                addr_q  <= src_q;
              end
`else
              state_q <= ST_RD_REQ;
              rnw_q   <= 1'b1;
              addr_q  <= src_q;
`endif
            end
          end
        end

        ST_RD_REQ: begin
          if (bus.dma_busynready) begin
            req_q   <= 1'b0;
            state_q <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (!bus.dma_busynready) begin
            wd_q <= bus.mem_dma_rd;
            if (abort_now) begin
              state_q   <= ST_FIN;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              aborted_q <= 1'b1;
            end else begin
              state_q <= ST_WR_REQ;
              req_q   <= 1'b1;
              rnw_q   <= 1'b0;
              addr_q  <= dst_q;
            end
          end
        end

        ST_WR_REQ: begin
          if (bus.dma_busynready) begin
            req_q   <= 1'b0;
            state_q <= ST_WR_WAIT;
          end
        end

        ST_WR_WAIT: begin
          if (!bus.dma_busynready) begin
            dst_q <= dst_inc;
            len_q <= len_q - LEN_W'(1);
`ifdef DMA_COPY_FILL_EN
            if (!fill_q) src_q <= src_inc;
`else
            src_q <= src_inc;
`endif
            if (last_byte || abort_now) begin
              state_q   <= ST_FIN;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              aborted_q <= !last_byte;
            end else begin
              req_q <= 1'b1;
`ifdef DMA_COPY_FILL_EN
              if (fill_q) begin
                state_q <= ST_WR_REQ;
                addr_q  <= dst_inc;
              end else begin
                state_q <= ST_RD_REQ;
                rnw_q   <= 1'b1;
                addr_q  <= src_inc;
              end
`else
              state_q <= ST_RD_REQ;
              rnw_q   <= 1'b1;
              addr_q  <= src_inc;
`endif
            end
          end
        end

        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;
  assign bus.dma_req  = req_q;
  assign bus.dma_rnw  = rnw_q;
  assign bus.dma_addr = addr_q;
  assign bus.dma_wd   = wd_q;

endmodule

// File: tb/tb_dma_copy_seq.sv
// Directed bench for dma_copy_seq with a small dma_access + byte RAM model.
// Fill-mode vectors run only when DMA_COPY_FILL_EN is defined.
module tb_dma_copy_seq;
  import dma_copy_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_copy_seq_if #(.ADDR_W(DEF_ADDR_W)) bus ();

  dma_copy_seq u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] mem [int];
  int n_checks = 0;
  int n_errors = 0;
  int n_done, n_rd, n_wr;
  logic busy_seen;
  logic [31:0] rnw_seq;
  logic [20:0] rd_addr_q[$];
  logic req_d = 1'b0;

  // dma_access stand-in: busy one edge after req, three edges in flight.
  logic [1:0]  lat_cnt;
  logic        lat_rnw;
  logic [20:0] lat_addr;
  logic [7:0]  lat_wd;
  logic [7:0]  rd_data;
  assign bus.mem_dma_rd = rd_data;

  function automatic logic [7:0] rd_mem(input int a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dma_busynready <= 1'b0;
      lat_cnt <= 2'd0;
      rd_data <= 8'h00;
    end else if (bus.dma_busynready) begin
      if (lat_cnt == 2'd0) begin
        bus.dma_busynready <= 1'b0;
        if (lat_rnw) rd_data <= rd_mem(int'(lat_addr));
        else mem[int'(lat_addr)] = lat_wd;
      end else begin
        lat_cnt <= lat_cnt - 2'd1;
      end
    end else if (bus.dma_req) begin
      bus.dma_busynready <= 1'b1;
      lat_cnt  <= 2'd2;
      lat_rnw  <= bus.dma_rnw;
      lat_addr <= bus.dma_addr;
      lat_wd   <= bus.dma_wd;
    end
  end

  always @(negedge clk) begin
    if (bus.done) n_done++;
    if (bus.busy) busy_seen = 1'b1;
    if (bus.dma_req && !req_d) begin
      rnw_seq = {rnw_seq[30:0], bus.dma_rnw};
      if (bus.dma_rnw) begin
        n_rd++;
        rd_addr_q.push_back(bus.dma_addr);
      end else begin
        n_wr++;
      end
    end
    req_d = bus.dma_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_done = 0; n_rd = 0; n_wr = 0;
    busy_seen = 1'b0;
    rnw_seq = '0;
    rd_addr_q.delete();
  endtask

  task automatic cfg_wr(input logic [1:0] sel, input logic [20:0] d);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_wd = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic setup(input logic [20:0] s, input logic [20:0] d, input logic [20:0] l);
    cfg_wr(CFG_SEL_SRC, s);
    cfg_wr(CFG_SEL_DST, d);
    cfg_wr(CFG_SEL_LEN, l);
  endtask

  initial begin
    logic found;
    bus.cfg_we = 1'b0; bus.cfg_sel = 2'd0; bus.cfg_wd = '0;
    bus.cfg_start = 1'b0; bus.cfg_abort = 1'b0;
    mem[32'h8000] = 8'h11; mem[32'h8001] = 8'h22;
    mem[32'h8002] = 8'h33; mem[32'h8003] = 8'h44;
    mem[32'h1FFFFE] = 8'h5A; mem[32'h1FFFFF] = 8'h6B; mem[32'h0] = 8'h7C;
    mem[32'h8402] = 8'hEE;
    clr();

    #12;
    check("rst_outs", {24'd0, bus.busy, bus.done, bus.aborted, bus.dma_req,
                       bus.dma_rnw, 3'd0}, 32'd0);
    check("rst_addr", 32'(bus.dma_addr), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Plain copy of four bytes; config write and start while busy must be ignored.
    setup(21'h08000, 21'h08100, 21'd4);
    clr();
    start_pulse();
    check("t1_busy", 32'(bus.busy), 32'd1);
    cfg_wr(CFG_SEL_LEN, 21'd5);
    start_pulse();
    wait_done("t1", 400);
    check("t1_m0", 32'(rd_mem(32'h8100)), 32'h11);
    check("t1_m1", 32'(rd_mem(32'h8101)), 32'h22);
    check("t1_m2", 32'(rd_mem(32'h8102)), 32'h33);
    check("t1_m3", 32'(rd_mem(32'h8103)), 32'h44);
    check("t1_nreq", 32'(n_rd + n_wr), 32'd8);
    check("t1_rnw_seq", 32'(rnw_seq[7:0]), 32'hAA);
    check("t1_ndone", 32'(n_done), 32'd1);
    check("t1_busy_end", 32'(bus.busy), 32'd0);

    // Length now 0 (counted down, busy write ignored): no access, done next cycle.
    repeat (3) @(negedge clk);
    clr();
    @(negedge clk); bus.cfg_start = 1'b1;
    @(negedge clk); bus.cfg_start = 1'b0;
    check("t2_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    check("t2_done_drop", 32'(bus.done), 32'd0);
    repeat (5) @(negedge clk);
    check("t2_nreq", 32'(n_rd + n_wr), 32'd0);
    check("t2_busy_seen", 32'(busy_seen), 32'd0);
    check("t2_ndone", 32'(n_done), 32'd1);

    // Source address wraps at the top of the 2 MB space.
    setup(21'h1FFFFE, 21'h08300, 21'd3);
    clr();
    start_pulse();
    wait_done("t3", 400);
    check("t3_nrd", 32'(n_rd), 32'd3);
    if (rd_addr_q.size() == 3) begin
      check("t3_a0", 32'(rd_addr_q[0]), 32'h1FFFFE);
      check("t3_a1", 32'(rd_addr_q[1]), 32'h1FFFFF);
      check("t3_a2", 32'(rd_addr_q[2]), 32'h000000);
    end
    check("t3_m2", 32'(rd_mem(32'h8302)), 32'h7C);

    // Abort while the third read is in flight.
    setup(21'h08000, 21'h08400, 21'd16);
    clr();
    start_pulse();
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (n_rd == 3 && bus.dma_rnw && !bus.dma_req && bus.dma_busynready) found = 1'b1;
    end
    if (!found) check("t4_rd3_timeout", 32'd0, 32'd1);
    bus.cfg_abort = 1'b1;
    @(negedge clk); bus.cfg_abort = 1'b0;
    wait_done("t4", 100);
    repeat (10) @(negedge clk);
    check("t4_nrd", 32'(n_rd), 32'd3);
    check("t4_nwr", 32'(n_wr), 32'd2);
    check("t4_m1", 32'(rd_mem(32'h8401)), 32'h22);
    check("t4_m2", 32'(rd_mem(32'h8402)), 32'hEE);
    check("t4_aborted", 32'(bus.aborted), 32'd1);
    check("t4_ndone", 32'(n_done), 32'd1);
    cfg_wr(CFG_SEL_LEN, 21'd0);
    start_pulse();
    check("t4_abort_clr", 32'(bus.aborted), 32'd0);

    // Asynchronous reset in the middle of a write.
    setup(21'h08000, 21'h08600, 21'd4);
    clr();
    start_pulse();
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (n_wr == 1 && !bus.dma_rnw && !bus.dma_req && bus.dma_busynready) found = 1'b1;
    end
    if (!found) check("t5_wr_timeout", 32'd0, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_req", 32'(bus.dma_req), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    clr();
    start_pulse();
    wait_done("t5a", 5);
    check("t5_len_cleared", 32'(n_rd + n_wr), 32'd0);
    setup(21'h08001, 21'h08700, 21'd1);
    clr();
    start_pulse();
    wait_done("t5b", 200);
    check("t5_m", 32'(rd_mem(32'h8700)), 32'h22);
    check("t5_nreq", 32'(n_rd + n_wr), 32'd2);

`ifdef DMA_COPY_FILL_EN
    // Fill three bytes with A5, no reads.
    cfg_wr(CFG_SEL_CTRL, 21'h0A501);
    setup(21'h08000, 21'h08200, 21'd3);
    clr();
    start_pulse();
    wait_done("t6", 300);
    check("t6_nrd", 32'(n_rd), 32'd0);
    check("t6_nwr", 32'(n_wr), 32'd3);
    check("t6_m0", 32'(rd_mem(32'h8200)), 32'hA5);
    check("t6_m2", 32'(rd_mem(32'h8202)), 32'hA5);
    cfg_wr(CFG_SEL_CTRL, 21'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
